// File: rtl/dsc_stoch2bin_win.sv
// Windowed stochastic-to-binary decoder: counts ones over 2^WIN_LOG2 qualified bits
// and hands the count out on a valid/ready handshake. Optional clamp: DSC_S2B_SAT_EN.
module dsc_stoch2bin_win #(
    parameter int WIN_LOG2  = 30,
    parameter int OUT_WIDTH = WIN_LOG2 + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sn_in,
    input  logic                 sn_valid,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] z,
    output logic                 z_valid,
    input  logic                 z_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIN_LOG2-1:0]   bit_cnt_q, bit_cnt_d;
    logic [OUT_WIDTH-1:0]  ones_cnt_q, ones_cnt_d;
    logic [OUT_WIDTH-1:0]  z_q, z_d;

    logic [OUT_WIDTH-1:0]  ones_sum;
    logic [OUT_WIDTH-1:0]  result;
    logic                  last_bit;

    assign ones_sum = ones_cnt_q + {{(OUT_WIDTH-1){1'b0}}, sn_in};
    assign last_bit = (bit_cnt_q == {WIN_LOG2{1'b1}});

`ifdef DSC_S2B_SAT_EN
    // Full scale is folded onto the largest fraction so the MSB is always 0.
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'({WIN_LOG2{1'b1}});
    assign result = (ones_sum > SAT_MAX) ? SAT_MAX : ones_sum;
`else
    assign result = ones_sum;
`endif

    always_comb begin
        // NOTE: every next-state value is defaulted to its current value first so no
        // path through the case statement leaves a variable unassigned (no latch).
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        z_d        = z_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                end
            end
            ACCUM: begin
                if (sn_valid) begin
                    bit_cnt_d  = bit_cnt_q + WIN_LOG2'(1);
                    ones_cnt_d = ones_sum;
                    if (last_bit) begin
                        z_d     = result;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Back-to-back windows restart straight from DONE without an IDLE bubble.
                if (z_ready) begin
                    if (start) begin
                        state_d    = ACCUM;
                        bit_cnt_d  = '0;
                        ones_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            z_q        <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            z_q        <= z_d;
        end
    end

    assign busy    = (state_q == ACCUM);
    assign z_valid = (state_q == DONE);
    assign z       = z_q;

endmodule
